// File: rtl/tl_mem_arbiter_pkg.sv
// Shared TileLink-UL definitions for the two-master memory arbiter: opcodes,
// default channel widths, channel structs and counter sizing.
package tl_mem_arbiter_pkg;

    localparam int TL_ADDR_W = 64;
    localparam int TL_DATA_W = 64;
    localparam int TL_MASK_W = TL_DATA_W / 8;
    localparam int TL_SRC_W  = 4;

    typedef enum logic [2:0] {
        TL_PUTFULL = 3'd0,
        TL_GET     = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        TL_ACK     = 3'd0,
        TL_ACKDATA = 3'd1
    } tl_d_op_e;

    // Downstream-side A beat; source carries the grant index in its MSB.
    typedef struct packed {
        logic [2:0]           opcode;
        logic [TL_ADDR_W-1:0] addr;
        logic [TL_DATA_W-1:0] data;
        logic [TL_MASK_W-1:0] mask;
        logic [TL_SRC_W:0]    source;
    } tlA_t;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [TL_DATA_W-1:0] data;
        logic [TL_SRC_W:0]    source;
        logic                 error;
    } tlD_t;

    // One spare bit so the counter can actually hold MAX_OUTSTD.
    function automatic int outstd_cnt_w(input int max_outstd);
        return $clog2(max_outstd) + 1;
    endfunction

endpackage

// File: rtl/tl_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from the request pair, pointer
// moves to the other master whenever a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt,
    output logic       o_gnt_idx
);

    logic r_ptr;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and a latch is inferred.
    always_comb begin
        o_gnt_idx = 1'b0;
        o_gnt     = 2'b00;
        case (i_req)
            2'b01:   o_gnt_idx = 1'b0;
            2'b10:   o_gnt_idx = 1'b1;
            2'b11:   o_gnt_idx = r_ptr;
            default: o_gnt_idx = 1'b0;
        endcase
        if (i_req != 2'b00) begin
            o_gnt = o_gnt_idx ? 2'b10 : 2'b01;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~o_gnt_idx;
        end
    end

endmodule

// File: rtl/tl_mem_arbiter.sv
// Shares one TileLink-UL port between fetch (0) and load/store (1): round-robin
// A arbitration into a one-entry buffer, D routed back by the source MSB.
module tl_mem_arbiter
    import tl_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = TL_ADDR_W,
    parameter int DATA_W     = TL_DATA_W,
    parameter int SRC_W      = TL_SRC_W,
    parameter int MAX_OUTSTD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               i_a_vld,
    output logic [1:0]               o_a_rdy,
    input  logic [1:0][2:0]          i_a_opcode,
    input  logic [1:0][ADDR_W-1:0]   i_a_addr,
    input  logic [1:0][DATA_W-1:0]   i_a_data,
    input  logic [1:0][DATA_W/8-1:0] i_a_mask,
    input  logic [1:0][SRC_W-1:0]    i_a_source,
    output logic [1:0]               o_d_vld,
    input  logic [1:0]               i_d_rdy,
    output logic [2:0]               o_d_opcode,
    output logic [DATA_W-1:0]        o_d_data,
    output logic [SRC_W-1:0]         o_d_source,
    output logic                     o_d_error,
    output logic                     o_m_a_vld,
    input  logic                     i_m_a_rdy,
    output logic [2:0]               o_m_a_opcode,
    output logic [ADDR_W-1:0]        o_m_a_addr,
    output logic [DATA_W-1:0]        o_m_a_data,
    output logic [DATA_W/8-1:0]      o_m_a_mask,
    output logic [SRC_W:0]           o_m_a_source,
    input  logic                     i_m_d_vld,
    output logic                     o_m_d_rdy,
    input  logic [2:0]               i_m_d_opcode,
    input  logic [DATA_W-1:0]        i_m_d_data,
    input  logic                     i_m_d_error,
    input  logic [SRC_W:0]           i_m_d_source
);

    localparam int CNT_W = outstd_cnt_w(MAX_OUTSTD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTD);

    typedef struct packed {
        logic [2:0]          opcode;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] mask;
        logic [SRC_W:0]      source;
    } a_req_t;

    logic             r_buf_vld;
    a_req_t           r_buf;
    logic [CNT_W-1:0] r_outstd [2];

    logic [1:0] w_elig;
    logic [1:0] w_gnt;
    logic       w_gnt_idx;
    logic       w_load;
    logic       w_accept;
    a_req_t     w_sel;
    logic       w_d_idx;
    logic       w_d_fire;
    logic [1:0] w_inc;
    logic [1:0] w_dec;

    // ------------------------------------------------------------------ A path
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_elig[k] = i_a_vld[k] && (r_outstd[k] < CNT_MAX);
        end
    end

    // The buffer refills in the same cycle it drains, giving 1 request/cycle.
    assign w_load   = !r_buf_vld || i_m_a_rdy;
    assign w_accept = w_load && (|w_elig);

    rr_arbiter2 u_rr_arbiter2 (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_elig),
        .i_accept  (w_accept),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign o_a_rdy = w_load ? w_gnt : 2'b00;

    always_comb begin
        w_sel.opcode = i_a_opcode[w_gnt_idx];
        w_sel.addr   = i_a_addr[w_gnt_idx];
        w_sel.data   = i_a_data[w_gnt_idx];
        w_sel.mask   = i_a_mask[w_gnt_idx];
        w_sel.source = {w_gnt_idx, i_a_source[w_gnt_idx]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_vld <= 1'b0;
        end else if (w_load) begin
            r_buf_vld <= w_accept;
        end
    end

    // NOTE: the payload register is left out of reset on purpose; it is only
    // observed while r_buf_vld is set, which is reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf <= w_sel;
        end
    end

    assign o_m_a_vld    = r_buf_vld;
    assign o_m_a_opcode = r_buf.opcode;
    assign o_m_a_addr   = r_buf.addr;
    assign o_m_a_data   = r_buf.data;
    assign o_m_a_mask   = r_buf.mask;
    assign o_m_a_source = r_buf.source;

    // ------------------------------------------------------------------ D path
    assign w_d_idx    = i_m_d_source[SRC_W];
    assign o_d_vld    = {i_m_d_vld && w_d_idx, i_m_d_vld && !w_d_idx};
    assign o_m_d_rdy  = i_d_rdy[w_d_idx];
    assign w_d_fire   = i_m_d_vld && o_m_d_rdy;
    assign o_d_opcode = i_m_d_opcode;
    assign o_d_data   = i_m_d_data;
    assign o_d_source = i_m_d_source[SRC_W-1:0];
    assign o_d_error  = i_m_d_error;

    // ---------------------------------------------------- outstanding counters
    for (genvar k = 0; k < 2; k++) begin : g_outstd
        assign w_inc[k] = o_a_rdy[k];
        assign w_dec[k] = w_d_fire && (w_d_idx == 1'(k));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_outstd[k] <= '0;
            end else begin
                case ({w_inc[k], w_dec[k]})
                    2'b10: r_outstd[k] <= r_outstd[k] + CNT_W'(1);
                    // A stray response must not wrap the counter to all-ones.
                    2'b01: if (r_outstd[k] != '0) r_outstd[k] <= r_outstd[k] - CNT_W'(1);
                    default: r_outstd[k] <= r_outstd[k];
                endcase
            end
        end

        a_no_underflow: assert property (@(posedge clk) disable iff (rst)
            !(w_dec[k] && !w_inc[k] && (r_outstd[k] == '0)));

        a_no_overflow: assert property (@(posedge clk) disable iff (rst)
            r_outstd[k] <= CNT_MAX);
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(o_a_rdy));

    a_hold_stalled: assert property (@(posedge clk) disable iff (rst)
        (r_buf_vld && !i_m_a_rdy) |=> (r_buf_vld && $stable(r_buf)));

endmodule

// File: tb/tb_tl_mem_arbiter.sv
// Randomised scoreboard bench for tl_mem_arbiter: a transaction-level model
// predicts each cycle; a separate monitor compares what the DUT presents.
module tb_tl_mem_arbiter;
    import tl_mem_arbiter_pkg::*;

    localparam int ADDR_W     = TL_ADDR_W;
    localparam int DATA_W     = TL_DATA_W;
    localparam int MASK_W     = TL_MASK_W;
    localparam int SRC_W      = TL_SRC_W;
    localparam int MAX_OUTSTD = 4;
    localparam int MAIN_CYC   = 400;
    localparam int DRAIN_CYC  = 300;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [1:0]             i_a_vld;
    logic [1:0]             o_a_rdy;
    logic [1:0][2:0]        i_a_opcode;
    logic [1:0][ADDR_W-1:0] i_a_addr;
    logic [1:0][DATA_W-1:0] i_a_data;
    logic [1:0][MASK_W-1:0] i_a_mask;
    logic [1:0][SRC_W-1:0]  i_a_source;
    logic [1:0]             o_d_vld;
    logic [1:0]             i_d_rdy;
    logic [2:0]             o_d_opcode;
    logic [DATA_W-1:0]      o_d_data;
    logic [SRC_W-1:0]       o_d_source;
    logic                   o_d_error;
    logic                   o_m_a_vld;
    logic                   i_m_a_rdy;
    logic [2:0]             o_m_a_opcode;
    logic [ADDR_W-1:0]      o_m_a_addr;
    logic [DATA_W-1:0]      o_m_a_data;
    logic [MASK_W-1:0]      o_m_a_mask;
    logic [SRC_W:0]         o_m_a_source;
    logic                   i_m_d_vld;
    logic                   o_m_d_rdy;
    logic [2:0]             i_m_d_opcode;
    logic [DATA_W-1:0]      i_m_d_data;
    logic                   i_m_d_error;
    logic [SRC_W:0]         i_m_d_source;

    tl_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .MAX_OUTSTD(MAX_OUTSTD)
    ) dut (
        .clk(clk), .rst(rst),
        .i_a_vld(i_a_vld), .o_a_rdy(o_a_rdy), .i_a_opcode(i_a_opcode),
        .i_a_addr(i_a_addr), .i_a_data(i_a_data), .i_a_mask(i_a_mask),
        .i_a_source(i_a_source),
        .o_d_vld(o_d_vld), .i_d_rdy(i_d_rdy), .o_d_opcode(o_d_opcode),
        .o_d_data(o_d_data), .o_d_source(o_d_source), .o_d_error(o_d_error),
        .o_m_a_vld(o_m_a_vld), .i_m_a_rdy(i_m_a_rdy), .o_m_a_opcode(o_m_a_opcode),
        .o_m_a_addr(o_m_a_addr), .o_m_a_data(o_m_a_data), .o_m_a_mask(o_m_a_mask),
        .o_m_a_source(o_m_a_source),
        .i_m_d_vld(i_m_d_vld), .o_m_d_rdy(o_m_d_rdy), .i_m_d_opcode(i_m_d_opcode),
        .i_m_d_data(i_m_d_data), .i_m_d_error(i_m_d_error), .i_m_d_source(i_m_d_source)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a_rdy;
        logic       m_vld;
        tlA_t       m_a;
        logic [1:0] d_vld;
        logic       m_d_rdy;
    } cyc_exp_t;

    typedef struct {
        int   master;
        tlD_t d;
    } d_exp_t;

    cyc_exp_t cyc_q[$];
    d_exp_t   d_exp_q[$];
    int       n_cmp = 0;
    int       n_err = 0;
    bit       mon_en = 1'b0;

    // Reference model: transactions, counts and "who went last", nothing more.
    bit   m_buf_vld;
    tlA_t m_buf;
    int   m_last;
    int   m_outstd [2];
    tlA_t pending[$];
    bit   mreq_vld [2];
    tlA_t mreq [2];
    bit   d_cur_vld;
    int   d_idx;
    tlD_t d_cur;
    int   p_win;
    int   p_dmaster;
    bit   p_load, p_drain, p_dfire;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic tlA_t rand_req();
        tlA_t r;
        r.opcode = ($urandom_range(0, 1) == 0) ? TL_GET : TL_PUTFULL;
        r.addr   = {$urandom, $urandom};
        r.data   = (r.opcode == TL_GET) ? '0 : {$urandom, $urandom};
        r.mask   = (r.opcode == TL_GET) ? '1 : MASK_W'($urandom);
        r.source = {1'b0, SRC_W'($urandom_range(0, 15))};
        return r;
    endfunction

    task automatic model_reset();
        m_buf_vld   = 1'b0;
        m_buf       = '0;
        m_last      = 1;
        m_outstd[0] = 0;
        m_outstd[1] = 0;
        pending.delete();
        mreq_vld[0] = 1'b0;
        mreq_vld[1] = 1'b0;
        d_cur_vld   = 1'b0;
        d_idx       = 0;
    endtask

    task automatic drive_and_predict(input int cyc, input bit do_rst);
        int        p_req [2];
        int        p_mrdy, p_dis, p_drdy;
        bit        only0;
        bit        elig [2];
        int        cand[$];
        cyc_exp_t  e;
        d_exp_t    de;

        only0 = 1'b0;
        if (cyc < 20)            begin p_req = '{50, 0};    p_mrdy = 100; p_dis = 60;  p_drdy = 100; end
        else if (cyc < 60)       begin p_req = '{100, 100}; p_mrdy = 100; p_dis = 100; p_drdy = 100; end
        else if (cyc < 100)      begin p_req = '{70, 70};   p_mrdy = 30;  p_dis = 50;  p_drdy = 70;  end
        else if (cyc < 160)      begin p_req = '{100, 100}; p_mrdy = 100; p_dis = 50;  p_drdy = 100; only0 = 1'b1; end
        else if (cyc < MAIN_CYC) begin p_req = '{50, 50};   p_mrdy = 60;  p_dis = 50;  p_drdy = 60;  end
        else                     begin p_req = '{0, 0};     p_mrdy = 100; p_dis = 100; p_drdy = 100; end

        rst = do_rst;
        for (int k = 0; k < 2; k++) begin
            if (!mreq_vld[k] && ($urandom_range(0, 99) < p_req[k])) begin
                mreq_vld[k] = 1'b1;
                mreq[k]     = rand_req();
            end
        end
        if (cyc == 0) begin
            mreq_vld[0] = 1'b1;
            mreq[0]     = '{opcode: TL_GET, addr: 64'h8000_0000, data: '0, mask: '1, source: 5'd3};
        end
        for (int k = 0; k < 2; k++) begin
            i_a_vld[k]    = mreq_vld[k] && !do_rst;
            i_a_opcode[k] = mreq[k].opcode;
            i_a_addr[k]   = mreq[k].addr;
            i_a_data[k]   = mreq[k].data;
            i_a_mask[k]   = mreq[k].mask;
            i_a_source[k] = mreq[k].source[SRC_W-1:0];
        end
        i_m_a_rdy = !do_rst && ($urandom_range(0, 99) < p_mrdy);

        // Downstream memory: answer any in-flight request, not only the oldest.
        if (!d_cur_vld && !do_rst && ($urandom_range(0, 99) < p_dis)) begin
            for (int i = 0; i < pending.size(); i++) begin
                if (!only0 || !pending[i].source[SRC_W]) cand.push_back(i);
            end
            if (cand.size() > 0) begin
                d_idx        = cand[$urandom_range(0, cand.size() - 1)];
                d_cur.opcode = (pending[d_idx].opcode == TL_GET) ? TL_ACKDATA : TL_ACK;
                d_cur.data   = (pending[d_idx].opcode == TL_GET) ? {$urandom, $urandom} : '0;
                d_cur.source = pending[d_idx].source;
                d_cur.error  = ($urandom_range(0, 7) == 0);
                d_cur_vld    = 1'b1;
            end
        end
        i_m_d_vld    = d_cur_vld && !do_rst;
        i_m_d_opcode = d_cur.opcode;
        i_m_d_data   = d_cur.data;
        i_m_d_error  = d_cur.error;
        i_m_d_source = d_cur_vld ? d_cur.source : '0;
        i_d_rdy[0]   = ($urandom_range(0, 99) < p_drdy);
        i_d_rdy[1]   = ($urandom_range(0, 99) < p_drdy);

        p_load  = !m_buf_vld || i_m_a_rdy;
        p_drain = m_buf_vld && i_m_a_rdy;
        for (int k = 0; k < 2; k++) elig[k] = i_a_vld[k] && (m_outstd[k] < MAX_OUTSTD);
        p_win = -1;
        if (p_load) begin
            if (elig[0] && elig[1]) p_win = 1 - m_last;
            else if (elig[0])       p_win = 0;
            else if (elig[1])       p_win = 1;
        end
        p_dmaster = int'(i_m_d_source[SRC_W]);
        p_dfire   = i_m_d_vld && i_d_rdy[p_dmaster];

        e.a_rdy   = (p_win < 0) ? 2'b00 : 2'(1 << p_win);
        e.m_vld   = m_buf_vld;
        e.m_a     = m_buf;
        e.d_vld   = i_m_d_vld ? 2'(1 << p_dmaster) : 2'b00;
        e.m_d_rdy = i_d_rdy[p_dmaster];
        cyc_q.push_back(e);
        if (p_dfire) begin
            de.master = p_dmaster;
            de.d      = d_cur;
            d_exp_q.push_back(de);
        end
    endtask

    task automatic model_update(input bit do_rst);
        if (do_rst) begin
            model_reset();
        end else begin
            if (p_drain) pending.push_back(m_buf);
            if (p_dfire) begin
                pending.delete(d_idx);
                m_outstd[p_dmaster]--;
                d_cur_vld = 1'b0;
            end
            if (p_load) begin
                m_buf_vld = (p_win >= 0);
                if (p_win >= 0) begin
                    m_buf          = mreq[p_win];
                    m_buf.source   = {p_win[0], mreq[p_win].source[SRC_W-1:0]};
                    m_last         = p_win;
                    m_outstd[p_win]++;
                    mreq_vld[p_win] = 1'b0;
                end
            end
        end
    endtask

    // Monitor: pops one cycle expectation per falling edge, plus D beats on handshake.
    initial begin
        cyc_exp_t e;
        d_exp_t   de;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("cycle_expectation_present", (cyc_q.size() != 0), 1'b1);
                if (cyc_q.size() != 0) begin
                    e = cyc_q.pop_front();
                    check("a_rdy", o_a_rdy, e.a_rdy);
                    check("m_a_vld", o_m_a_vld, e.m_vld);
                    if (e.m_vld) begin
                        check("m_a_payload",
                              {o_m_a_opcode, o_m_a_addr, o_m_a_data, o_m_a_mask, o_m_a_source}, e.m_a);
                    end
                    check("d_vld", o_d_vld, e.d_vld);
                    check("m_d_rdy", o_m_d_rdy, e.m_d_rdy);
                end
                for (int k = 0; k < 2; k++) begin
                    if (o_d_vld[k] && i_d_rdy[k]) begin
                        check("d_beat_expected", (d_exp_q.size() != 0), 1'b1);
                        if (d_exp_q.size() != 0) begin
                            de = d_exp_q.pop_front();
                            check("d_master", k, de.master);
                            check("d_opcode", o_d_opcode, de.d.opcode);
                            check("d_data", o_d_data, de.d.data);
                            check("d_source", o_d_source, de.d.source[SRC_W-1:0]);
                            check("d_error", o_d_error, de.d.error);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit idle;
        i_a_vld = '0; i_a_opcode = '0; i_a_addr = '0; i_a_data = '0; i_a_mask = '0;
        i_a_source = '0; i_d_rdy = '0; i_m_a_rdy = 1'b0; i_m_d_vld = 1'b0;
        i_m_d_opcode = '0; i_m_d_data = '0; i_m_d_error = 1'b0; i_m_d_source = '0;
        d_cur = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        mon_en = 1'b1;

        for (int cyc = 0; cyc < MAIN_CYC; cyc++) begin
            drive_and_predict(cyc, (cyc == 250) || (cyc == 251));
            @(posedge clk);
            model_update((cyc == 250) || (cyc == 251));
            #1;
        end

        idle = 1'b0;
        for (int cyc = MAIN_CYC; cyc < MAIN_CYC + DRAIN_CYC; cyc++) begin
            idle = !m_buf_vld && (pending.size() == 0) && !d_cur_vld && !mreq_vld[0] && !mreq_vld[1];
            if (idle) break;
            drive_and_predict(cyc, 1'b0);
            @(posedge clk);
            model_update(1'b0);
            #1;
        end
        mon_en = 1'b0;

        check("drain_completed", idle, 1'b1);
        check("d_expectations_left", d_exp_q.size(), 0);
        check("cycle_expectations_left", cyc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
